// File: rtl/frame_aligner_mc_pkg.sv
// Shared types and helpers for the multi-group frame aligner.
package frame_align_pkg;

   typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

   localparam int FRAME_SIZE_SDR = 8;
   localparam int FRAME_SIZE_DDR = 16;
   localparam int MAX_FRAME      = 64;

   // Only meaningful for a one-hot argument; returns the highest set bit otherwise.
   function automatic int unsigned onehot_to_idx(input logic [MAX_FRAME-1:0] oh);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < MAX_FRAME; i++)
         if (oh[i]) idx = i;
      return idx;
   endfunction

endpackage

// File: rtl/frame_aligner_mc_if.sv
// S-bit / SoT bus of the frame aligner. FRAME_ALIGN_ERRCNT_EN adds sot_err_cnt.
interface frame_aligner_mc_if #(
   parameter int FRAME_SIZE = 8,
   parameter int NUM_GROUPS = 8,
   parameter int CNT_W      = 12,
   parameter int SLIP_W     = $clog2(FRAME_SIZE)
);
   logic [NUM_GROUPS*FRAME_SIZE-1:0] sbits_i;
   logic [FRAME_SIZE-1:0]            start_of_frame;
   logic                             mask;
   logic [CNT_W-1:0]                 aligned_count_to_ready;
   logic [3:0]                       err_thresh;
   logic                             clear_unstable;
   logic [NUM_GROUPS*FRAME_SIZE-1:0] sbits_o;
   logic                             sot_is_aligned;
   logic                             sot_unstable;
   logic [SLIP_W-1:0]                bitslip_cnt_o;
`ifdef FRAME_ALIGN_ERRCNT_EN
   logic [15:0]                      sot_err_cnt;
`endif

   modport master (
      output sbits_i, start_of_frame, mask, aligned_count_to_ready, err_thresh, clear_unstable,
      input  sbits_o, sot_is_aligned, sot_unstable, bitslip_cnt_o
`ifdef FRAME_ALIGN_ERRCNT_EN
      , input sot_err_cnt
`endif
   );

   modport slave (
      input  sbits_i, start_of_frame, mask, aligned_count_to_ready, err_thresh, clear_unstable,
      output sbits_o, sot_is_aligned, sot_unstable, bitslip_cnt_o
`ifdef FRAME_ALIGN_ERRCNT_EN
      , output sot_err_cnt
`endif
   );

endinterface

// File: rtl/frame_aligner_mc_bitslip.sv
// One group's slice: previous-frame register, barrel select over two frames, zeroable output.
module frame_bitslip #(
   parameter int FRAME_SIZE = 8,
   parameter int SLIP_W     = $clog2(FRAME_SIZE)
) (
   input  logic                  clock,
   input  logic                  reset_n_i,
   input  logic [FRAME_SIZE-1:0] din,
   input  logic [SLIP_W-1:0]     slip,
   input  logic                  zero,
   output logic [FRAME_SIZE-1:0] dout
);
   logic [FRAME_SIZE-1:0]   din_d1;
   logic [2*FRAME_SIZE-1:0] cat;

   assign cat = {din, din_d1};

   always_ff @(posedge clock or negedge reset_n_i) begin
      if (!reset_n_i) begin
         din_d1 <= '0;
         dout   <= '0;
      end else begin
         din_d1 <= din;
         dout   <= zero ? '0 : cat[slip +: FRAME_SIZE];
      end
   end

endmodule

// File: rtl/frame_aligner_mc.sv
// SoT-driven frame aligner sharing one frozen bitslip across NUM_GROUPS groups.
// Optional macro FRAME_ALIGN_ERRCNT_EN adds a saturating bad-SoT counter.
module frame_aligner_mc
   import frame_align_pkg::*;
#(
   parameter int FRAME_SIZE = 8,
   parameter int NUM_GROUPS = 8,
   parameter int SOT_OFFSET = 1,
   parameter int CNT_W      = 12,
   parameter int SLIP_W     = $clog2(FRAME_SIZE)
) (
   input  logic               clock,
   input  logic               reset_n_i,
   frame_aligner_mc_if.slave  bus
);
   state_t                state;
   logic [CNT_W-1:0]      stable_cnt, stable_nxt, lock_thr;
   logic [3:0]            err_run, err_thr;
   logic [4:0]            err_inc;
   logic [FRAME_SIZE-1:0] sof_d1, sof_lock;
   logic [SLIP_W-1:0]     cand_slip, slip;
   logic                  sof_valid, sof_bad, gain_lock, lose_lock, keep_data;
   logic                  aligned, unstable;

   always_comb begin
      sof_valid = $onehot(bus.start_of_frame);
      cand_slip = SLIP_W'((onehot_to_idx(MAX_FRAME'(bus.start_of_frame)) + SOT_OFFSET) % FRAME_SIZE);
      lock_thr  = (bus.aligned_count_to_ready == '0) ? CNT_W'(1) : bus.aligned_count_to_ready;
      err_thr   = (bus.err_thresh == 4'd0) ? 4'd1 : bus.err_thresh;
      if (!sof_valid)
         stable_nxt = '0;
      else if (bus.start_of_frame == sof_d1)
         stable_nxt = (&stable_cnt) ? stable_cnt : stable_cnt + 1'b1;
      else
         stable_nxt = CNT_W'(1);
      gain_lock = (state == SEARCH) && (stable_nxt >= lock_thr);
      sof_bad   = (bus.start_of_frame != sof_lock);
      err_inc   = {1'b0, err_run} + 5'd1;
      lose_lock = (state == LOCKED) && sof_bad && (err_inc >= {1'b0, err_thr});
      // Output is live only for cycles that start and end in LOCKED.
      keep_data = (state == LOCKED) && !lose_lock && !bus.mask;
   end

   always_ff @(posedge clock or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state      <= SEARCH;
         stable_cnt <= '0;
         err_run    <= '0;
         sof_d1     <= '0;
         sof_lock   <= '0;
         slip       <= '0;
         aligned    <= 1'b0;
         unstable   <= 1'b0;
      end else begin
         sof_d1 <= bus.start_of_frame;
         case (state)
            SEARCH: begin
               stable_cnt <= stable_nxt;
               err_run    <= '0;
               if (gain_lock) begin
                  state    <= LOCKED;
                  aligned  <= 1'b1;
                  sof_lock <= bus.start_of_frame;
                  slip     <= cand_slip;
               end
            end
            LOCKED: begin
               if (lose_lock) begin
                  state      <= SEARCH;
                  aligned    <= 1'b0;
                  stable_cnt <= '0;
                  err_run    <= '0;
               end else if (sof_bad) begin
                  err_run <= err_inc[3:0];
               end else begin
                  err_run <= '0;
               end
            end
         endcase
         if (lose_lock)
            unstable <= 1'b1;
         else if (bus.clear_unstable)
            unstable <= 1'b0;
      end
   end

`ifdef FRAME_ALIGN_ERRCNT_EN
   logic [15:0] err_cnt;

   always_ff @(posedge clock or negedge reset_n_i) begin
      if (!reset_n_i)
         err_cnt <= '0;
      else if (bus.clear_unstable)
         err_cnt <= '0;
      else if ((state == LOCKED) && sof_bad && !(&err_cnt))
         err_cnt <= err_cnt + 16'd1;
   end

   assign bus.sot_err_cnt = err_cnt;
`endif

   assign bus.sot_is_aligned = aligned;
   assign bus.sot_unstable   = unstable;
   assign bus.bitslip_cnt_o  = slip;

   for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
      frame_bitslip #(.FRAME_SIZE(FRAME_SIZE), .SLIP_W(SLIP_W)) u_slip (
         .clock     (clock),
         .reset_n_i (reset_n_i),
         .din       (bus.sbits_i[g*FRAME_SIZE +: FRAME_SIZE]),
         .slip      (slip),
         .zero      (!keep_data),
         .dout      (bus.sbits_o[g*FRAME_SIZE +: FRAME_SIZE])
      );
   end

endmodule

// File: tb/tb_frame_aligner_mc.sv
// Directed bench for frame_aligner_mc with a cycle-level reference model.
module tb_frame_aligner_mc;
   localparam int FS = 8, NG = 8, CW = 12, SW = 3, OFF = 1;

   logic clock = 1'b0;
   logic reset_n_i;
   always #5 clock = ~clock;

   frame_aligner_mc_if #(.FRAME_SIZE(FS), .NUM_GROUPS(NG), .CNT_W(CW), .SLIP_W(SW)) bus();

   frame_aligner_mc #(.FRAME_SIZE(FS), .NUM_GROUPS(NG), .SOT_OFFSET(OFF), .CNT_W(CW), .SLIP_W(SW)) dut (
      .clock     (clock),
      .reset_n_i (reset_n_i),
      .bus       (bus)
   );

   int total = 0, bad = 0;
   bit chk_en = 1'b0;

   bit          m_locked, m_unst;
   logic [7:0]  m_lock_sot, m_prev;
   int          m_slip, m_run, m_bad;
   logic [63:0] m_sbits, m_d1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_unst = 0; m_lock_sot = '0; m_prev = '0;
      m_slip = 0; m_run = 0; m_bad = 0; m_sbits = '0; m_d1 = '0;
   endtask

   // Rules applied once per clock edge to the inputs presented at that edge.
   task automatic model_update();
      logic [7:0]  s;
      logic [15:0] c;
      bit valid, was, lost;
      int k, need, ethr;
      s = bus.start_of_frame;
      valid = ($countones(s) == 1);
      k = 0;
      for (int i = 0; i < FS; i++) if (s[i]) k = i;
      was = m_locked;
      lost = 0;
      if (!m_locked) begin
         if (!valid) m_run = 0;
         else if (s == m_prev) m_run++;
         else m_run = 1;
         need = (bus.aligned_count_to_ready == 0) ? 1 : int'(bus.aligned_count_to_ready);
         if (m_run >= need) begin
            m_locked = 1; m_lock_sot = s; m_slip = (k + OFF) % FS; m_bad = 0;
         end
      end else begin
         if (s == m_lock_sot) m_bad = 0; else m_bad++;
         ethr = (bus.err_thresh == 0) ? 1 : int'(bus.err_thresh);
         if (m_bad >= ethr) begin
            m_locked = 0; m_run = 0; m_bad = 0; lost = 1;
         end
      end
      m_sbits = '0;
      if (was && m_locked && !bus.mask)
         for (int g = 0; g < NG; g++) begin
            c = {bus.sbits_i[g*FS +: FS], m_d1[g*FS +: FS]};
            c = c >> m_slip;
            m_sbits[g*FS +: FS] = c[7:0];
         end
      if (lost) m_unst = 1;
      else if (bus.clear_unstable) m_unst = 0;
      m_prev = s;
      m_d1 = bus.sbits_i;
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         check("sbits_o",  bus.sbits_o, m_sbits);
         check("aligned",  64'(bus.sot_is_aligned), 64'(m_locked));
         check("unstable", 64'(bus.sot_unstable), 64'(m_unst));
         check("slip",     64'(bus.bitslip_cnt_o), 64'(m_locked || m_slip != 0 ? m_slip : 0));
      end
   end

   task automatic step(input logic [7:0] sof, input logic [63:0] d);
      bus.start_of_frame = sof;
      bus.sbits_i = d;
      @(posedge clock);
      model_update();
      #1;
   endtask

   function automatic logic [63:0] rnd();
      return {$urandom, $urandom};
   endfunction

   logic [63:0] x_dat;
   int seen;

   initial begin
      reset_n_i = 1'b0;
      bus.sbits_i = '0; bus.start_of_frame = '0; bus.mask = 0; bus.clear_unstable = 0;
      bus.aligned_count_to_ready = 12'd4; bus.err_thresh = 4'd3;
      model_reset();
      repeat (2) @(posedge clock);
      #1 reset_n_i = 1'b1;
      chk_en = 1'b1;
      check("rst_aligned", 64'(bus.sot_is_aligned), 64'd0);
      check("rst_unstable", 64'(bus.sot_unstable), 64'd0);
      check("rst_slip", 64'(bus.bitslip_cnt_o), 64'd0);
      check("rst_sbits", bus.sbits_o, 64'd0);

      // Lock on 8'h01 after four identical SoTs
      for (int i = 0; i < 4; i++) begin
         step(8'h01, rnd());
         check("s1_aligned", 64'(bus.sot_is_aligned), 64'(i == 3));
      end
      check("s1_slip", 64'(bus.bitslip_cnt_o), 64'd1);
      repeat (3) step(8'h01, rnd());

      step(8'h01, {8{8'hA5}});
      step(8'h01, {8{8'h3C}});
      check("s2_g0", 64'(bus.sbits_o[7:0]), 64'h52);
      check("s2_all", bus.sbits_o, {8{8'h52}});
      repeat (20) step(8'h01, rnd());

      // Two bad then good holds lock; three bad drops it
      step(8'h02, rnd()); step(8'h00, rnd()); step(8'h01, rnd());
      check("s3_hold_aligned", 64'(bus.sot_is_aligned), 64'd1);
      check("s3_hold_unstable", 64'(bus.sot_unstable), 64'd0);
      step(8'h04, rnd()); step(8'h02, rnd()); step(8'h03, rnd());
      check("s3_drop_aligned", 64'(bus.sot_is_aligned), 64'd0);
      check("s3_drop_unstable", 64'(bus.sot_unstable), 64'd1);
      check("s3_drop_sbits", bus.sbits_o, 64'd0);

      // Clear racing a lock loss
      repeat (4) step(8'h01, rnd());
      check("s5_relock", 64'(bus.sot_is_aligned), 64'd1);
      check("s5_sticky", 64'(bus.sot_unstable), 64'd1);
      step(8'h02, rnd()); step(8'h02, rnd());
      bus.clear_unstable = 1;
      step(8'h02, rnd());
      check("s5_race", 64'(bus.sot_unstable), 64'd1);
      step(8'h01, rnd());
      check("s5_clear", 64'(bus.sot_unstable), 64'd0);
      bus.clear_unstable = 0;

      // Alternating SoT never locks; an invalid SoT restarts the count
      bus.aligned_count_to_ready = 12'd2;
      seen = 0;
      for (int i = 0; i < 5000; i++) begin
         step((i % 2 == 0) ? 8'h02 : 8'h01, rnd());
         if (bus.sot_is_aligned) seen++;
      end
      check("s4_never", 64'(seen), 64'd0);
      step(8'h03, rnd());
      check("s4_inv", 64'(bus.sot_is_aligned), 64'd0);
      step(8'h01, rnd());
      check("s4_one", 64'(bus.sot_is_aligned), 64'd0);
      step(8'h01, rnd());
      check("s4_lock", 64'(bus.sot_is_aligned), 64'd1);

      // Relock on 8'h80 -> slip 0 passes the previous frame straight through
      repeat (3) step(8'h00, rnd());
      check("s1b_lost", 64'(bus.sot_is_aligned), 64'd0);
      step(8'h80, rnd()); step(8'h80, rnd());
      check("s1b_aligned", 64'(bus.sot_is_aligned), 64'd1);
      check("s1b_slip", 64'(bus.bitslip_cnt_o), 64'd0);
      x_dat = rnd();
      step(8'h80, x_dat);
      step(8'h80, rnd());
      check("s1b_data", bus.sbits_o, x_dat);

      bus.mask = 1;
      step(8'h80, rnd());
      check("s6_mask_sbits", bus.sbits_o, 64'd0);
      check("s6_mask_lock", 64'(bus.sot_is_aligned), 64'd1);
      bus.mask = 0;
      step(8'h80, rnd());

      // Asynchronous reset mid-lock, away from any clock edge
      #2 reset_n_i = 1'b0;
      #1;
      check("s6_rst_sbits", bus.sbits_o, 64'd0);
      check("s6_rst_aligned", 64'(bus.sot_is_aligned), 64'd0);
      check("s6_rst_unstable", 64'(bus.sot_unstable), 64'd0);
      check("s6_rst_slip", 64'(bus.bitslip_cnt_o), 64'd0);
      model_reset();
      @(posedge clock);
      #1 reset_n_i = 1'b1;
      step(8'h01, rnd()); step(8'h01, rnd());
      check("s6_after_rst", 64'(bus.sot_is_aligned), 64'd1);
      repeat (3) step(8'h01, rnd());

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
